// File: rtl/nqueen_pkg.sv
// Shared definitions for the N-queens engine: FSM states, mode encoding and
// diagonal index helpers used by the controller and the occupancy bank.
package nqueen_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SEARCH = 3'd2,
        S_BACK   = 3'd3,
        S_OUT    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic MODE_FIRST = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // Anti-diagonal index: constant along r+c.
    function automatic int d1_idx(input int r, input int c);
        return r + c;
    endfunction

    // Main-diagonal index: r-c shifted by n-1 so it is never negative.
    function automatic int d2_idx(input int r, input int c, input int n);
        return r - c + n - 1;
    endfunction

endpackage

// File: rtl/nqueen_occupancy.sv
// Row / anti-diagonal / diagonal occupancy bank. One set-or-clear write port,
// a combinational safety query and a hit flag for the square being written.
module nqueen_occupancy
    import nqueen_pkg::*;
#(
    parameter int N = 12,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_all_i,
    input  logic         wr_en_i,
    input  logic         wr_set_i,
    input  logic [W-1:0] wr_r_i,
    input  logic [W-1:0] wr_c_i,
    input  logic [W-1:0] q_r_i,
    input  logic [W-1:0] q_c_i,
    output logic         safe_o,
    output logic         hit_o
);

    // Diagonal indices reach 2N-2, so they carry one extra bit. Masks are
    // sized to the full index range so any index value selects a real bit.
    localparam int DW = W + 1;
    localparam int NR = 2 ** W;
    localparam int ND = 2 ** DW;

    logic [NR-1:0] rowm_q;
    logic [ND-1:0] d1_q;
    logic [ND-1:0] d2_q;

    logic [DW-1:0] wr_d1, wr_d2, q_d1, q_d2;

    assign wr_d1 = DW'(d1_idx(int'(wr_r_i), int'(wr_c_i)));
    assign wr_d2 = DW'(d2_idx(int'(wr_r_i), int'(wr_c_i), N));
    assign q_d1  = DW'(d1_idx(int'(q_r_i), int'(q_c_i)));
    assign q_d2  = DW'(d2_idx(int'(q_r_i), int'(q_c_i), N));

    assign hit_o  = rowm_q[wr_r_i] | d1_q[wr_d1] | d2_q[wr_d2];
    assign safe_o = ~(rowm_q[q_r_i] | d1_q[q_d1] | d2_q[q_d2]);

    // Mask update: wipe on reset/job end, otherwise set or clear one queen.
    always_ff @(posedge clk) begin
        if (rst || clr_all_i) begin
            rowm_q <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
        end else if (wr_en_i) begin
            rowm_q[wr_r_i] <= wr_set_i;
            d1_q[wr_d1]    <= wr_set_i;
            d2_q[wr_d2]    <= wr_set_i;
        end
    end

endmodule

// File: rtl/nqueen_solver.sv
// N-queens backtracking engine. Pre-placed queens arrive serially; the engine
// then returns either the first completed board (column order) or the number
// of completions. Handshake: in_valid is a single-cycle beat with no
// back-pressure, in_valid_num marks the first beat of a job; out_valid marks
// each result beat and the result fields are zero whenever it is low.
module nqueen_solver
    import nqueen_pkg::*;
#(
    parameter int N  = 12,
    parameter int W  = $clog2(N + 1),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  col,
    input  logic [W-1:0]  row,
    input  logic          in_valid_num,
    input  logic [W-1:0]  in_num,
    input  logic          in_mode,
    output logic          out_valid,
    output logic [W-1:0]  out,
    output logic [CW-1:0] out_cnt,
    output logic          out_fail,
    output logic [2:0]    dbg_state
);

    localparam int             NP  = 2 ** W;
    localparam logic [W-1:0]   NW  = W'(N);
    localparam logic [W-1:0]   ONE = W'(1);

    state_t        state_q;
    logic          mode_q;
    logic [W-1:0]  k_q, ld_cnt_q, c_q, r_q, idx_q;
    logic          conflict_q;
    logic [CW-1:0] cnt_q;
    logic [NP-1:0] fixed_q;
    logic [W-1:0]  pos_q [NP];

    logic          out_valid_q, out_fail_q;
    logic [W-1:0]  out_q;
    logic [CW-1:0] out_cnt_q;

    logic          wr_en, wr_set;
    logic [W-1:0]  wr_r, wr_c;
    logic          occ_safe, occ_hit, clr_all;
    logic          load_beat, ld_mode, ld_last, ld_conf, try_place;
    logic          bk_found;
    logic [W-1:0]  bk_c;

    assign load_beat = in_valid && ((state_q == S_IDLE && in_valid_num) || state_q == S_LOAD);
    assign ld_mode   = (state_q == S_IDLE) ? in_mode : mode_q;
    assign ld_last   = (state_q == S_IDLE) ? (in_num == ONE) : (ld_cnt_q + ONE == k_q);
    assign ld_conf   = conflict_q | occ_hit | fixed_q[col];
    assign try_place = (state_q == S_SEARCH) && (c_q != NW) && !fixed_q[c_q]
                       && (r_q != NW) && occ_safe;
    assign clr_all   = (state_q == S_DONE) || (state_q == S_OUT && idx_q == NW);

    // Backtrack target: highest free (non-fixed) column strictly below c.
    always_comb begin
        bk_found = 1'b0;
        bk_c     = '0;
        for (int i = 0; i < N; i++) begin
            if (W'(i) < c_q && !fixed_q[W'(i)]) begin
                bk_found = 1'b1;
                bk_c     = W'(i);
            end
        end
    end

    // Occupancy write port: load beats, trial placements and backtrack removals.
    always_comb begin
        wr_en  = 1'b0;
        wr_set = 1'b1;
        wr_r   = row;
        wr_c   = col;
        if (load_beat) begin
            wr_en = 1'b1;
        end else if (try_place) begin
            wr_en = 1'b1;
            wr_r  = r_q;
            wr_c  = c_q;
        end else if (state_q == S_BACK && bk_found) begin
            wr_en  = 1'b1;
            wr_set = 1'b0;
            wr_r   = pos_q[bk_c];
            wr_c   = bk_c;
        end
    end

    nqueen_occupancy #(.N(N), .W(W)) u_occ (
        .clk       (clk),
        .rst       (rst),
        .clr_all_i (clr_all),
        .wr_en_i   (wr_en),
        .wr_set_i  (wr_set),
        .wr_r_i    (wr_r),
        .wr_c_i    (wr_c),
        .q_r_i     (r_q),
        .q_c_i     (c_q),
        .safe_o    (occ_safe),
        .hit_o     (occ_hit)
    );

    // Board record: row of each column and which columns were pre-placed.
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            fixed_q <= '0;
            for (int i = 0; i < NP; i++) pos_q[i] <= '0;
        end else if (wr_en && wr_set) begin
            pos_q[wr_c] <= wr_r;
            if (load_beat) fixed_q[wr_c] <= 1'b1;
        end
    end

    // Controller FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_FIRST;
            k_q         <= '0;
            ld_cnt_q    <= '0;
            c_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            conflict_q  <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            out_fail_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (load_beat) begin
                        if (state_q == S_IDLE) begin
                            mode_q <= in_mode;
                            k_q    <= in_num;
                        end
                        ld_cnt_q   <= ld_cnt_q + ONE;
                        conflict_q <= ld_conf;
                        if (ld_last) begin
                            if (ld_conf) begin
                                state_q     <= S_DONE;
                                out_valid_q <= 1'b1;
                                out_q       <= '0;
                                out_cnt_q   <= '0;
                                out_fail_q  <= (ld_mode == MODE_FIRST);
                            end else begin
                                state_q <= S_SEARCH;
                                c_q     <= '0;
                                r_q     <= '0;
                                cnt_q   <= '0;
                            end
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_SEARCH: begin
                    if (c_q == NW) begin
                        if (mode_q == MODE_FIRST) begin
                            state_q     <= S_OUT;
                            out_valid_q <= 1'b1;
                            out_q       <= pos_q[0];
                            idx_q       <= ONE;
                        end else begin
                            if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
                            state_q <= S_BACK;
                        end
                    end else if (fixed_q[c_q]) begin
                        c_q <= c_q + ONE;
                    end else if (r_q == NW) begin
                        state_q <= S_BACK;
                    end else if (occ_safe) begin
                        c_q <= c_q + ONE;
                        r_q <= '0;
                    end else begin
                        r_q <= r_q + ONE;
                    end
                end
                S_BACK: begin
                    if (!bk_found) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= '0;
                        out_fail_q  <= (mode_q == MODE_FIRST);
                        out_cnt_q   <= (mode_q == MODE_COUNT) ? cnt_q : '0;
                    end else begin
                        c_q     <= bk_c;
                        r_q     <= pos_q[bk_c] + ONE;
                        state_q <= S_SEARCH;
                    end
                end
                S_OUT: begin
                    if (idx_q == NW) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_q       <= '0;
                        cnt_q       <= '0;
                        conflict_q  <= 1'b0;
                        ld_cnt_q    <= '0;
                    end else begin
                        out_q <= pos_q[idx_q];
                        idx_q <= idx_q + ONE;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    out_q       <= '0;
                    out_cnt_q   <= '0;
                    out_fail_q  <= 1'b0;
                    cnt_q       <= '0;
                    conflict_q  <= 1'b0;
                    ld_cnt_q    <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_cnt   = out_cnt_q;
    assign out_fail  = out_fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nqueen_solver.sv
// Bench for nqueen_solver: three instances (N=4, 8, 12) share one clock and
// reset; each job is checked against a software backtracking solver.
module tb_nqueen_solver;
    import nqueen_pkg::*;

    localparam int LIMIT = 30000;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       ivn, mode_b, iv4, iv8, iv12;
    logic [3:0] col_b, row_b, num_b;
    logic       ov4, ov8, ov12, f4, f8, f12;
    logic [2:0] o4;
    logic [3:0] o8, o12;
    logic [15:0] c4, c8, c12;
    logic [2:0] st4, st8, st12;

    nqueen_solver #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .col(col_b[2:0]), .row(row_b[2:0]),
        .in_valid_num(ivn), .in_num(num_b[2:0]), .in_mode(mode_b),
        .out_valid(ov4), .out(o4), .out_cnt(c4), .out_fail(f4), .dbg_state(st4));
    nqueen_solver #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .col(col_b), .row(row_b),
        .in_valid_num(ivn), .in_num(num_b), .in_mode(mode_b),
        .out_valid(ov8), .out(o8), .out_cnt(c8), .out_fail(f8), .dbg_state(st8));
    nqueen_solver #(.N(12)) u12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .col(col_b), .row(row_b),
        .in_valid_num(ivn), .in_num(num_b), .in_mode(mode_b),
        .out_valid(ov12), .out(o12), .out_cnt(c12), .out_fail(f12), .dbg_state(st12));

    int n_cmp = 0;
    int n_bad = 0;

    // Current job description
    int   job_sel, job_n, job_k;
    logic job_mode;
    int   job_c[16], job_r[16];

    // Reference results and captured beats
    int   exp_board[16];
    bit   exp_found;
    int   exp_count;
    logic [31:0] exp_q[$];
    int   got_out[17], got_cnt[17], got_fail[17];
    int   got_beats, lat;
    bit   timed_out;

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Two queens on distinct squares do not attack each other.
    function automatic bit compat(input int c1, input int r1, input int c2, input int r2);
        int dr, dc;
        dr = r1 - r2; if (dr < 0) dr = -dr;
        dc = c1 - c2; if (dc < 0) dc = -dc;
        return (c1 != c2) && (r1 != r2) && (dr != dc);
    endfunction

    // Software solver: depth-first over free columns, rows ascending.
    task automatic ref_solve();
        int b[16];
        bit fx[16];
        int fc[16];
        int nf, d;
        bit conf, ok;
        for (int i = 0; i < 16; i++) begin b[i] = -1; fx[i] = 0; exp_board[i] = 0; end
        conf = 0;
        for (int i = 0; i < job_k; i++) begin
            for (int j = 0; j < i; j++)
                if (!compat(job_c[i], job_r[i], job_c[j], job_r[j])) conf = 1;
            b[job_c[i]] = job_r[i];
            fx[job_c[i]] = 1;
        end
        exp_found = 0;
        exp_count = 0;
        if (conf) return;
        nf = 0;
        for (int c = 0; c < job_n; c++) if (!fx[c]) begin fc[nf] = c; nf++; end
        d = 0;
        while (d >= 0) begin
            if (d == nf) begin
                exp_count++;
                if (!exp_found) begin
                    exp_found = 1;
                    for (int c = 0; c < job_n; c++) exp_board[c] = b[c];
                end
                if (job_mode == MODE_FIRST) break;
                d--;
                continue;
            end
            b[fc[d]]++;
            if (b[fc[d]] >= job_n) begin
                b[fc[d]] = -1;
                d--;
                continue;
            end
            ok = 1;
            for (int c = 0; c < job_n; c++)
                if (c != fc[d] && b[c] >= 0 && !compat(fc[d], b[fc[d]], c, b[c])) ok = 0;
            if (ok) d++;
        end
    endtask

    function automatic logic [31:0] dut_ov();
        case (job_sel)
            4: return {31'd0, ov4};
            8: return {31'd0, ov8};
            default: return {31'd0, ov12};
        endcase
    endfunction
    function automatic logic [31:0] dut_out();
        case (job_sel)
            4: return {29'd0, o4};
            8: return {28'd0, o8};
            default: return {28'd0, o12};
        endcase
    endfunction
    function automatic logic [31:0] dut_cnt();
        case (job_sel)
            4: return {16'd0, c4};
            8: return {16'd0, c8};
            default: return {16'd0, c12};
        endcase
    endfunction
    function automatic logic [31:0] dut_fail();
        case (job_sel)
            4: return {31'd0, f4};
            8: return {31'd0, f8};
            default: return {31'd0, f12};
        endcase
    endfunction

    // Driver tasks
    task automatic set_job(input int sel, input logic mode);
        job_sel = sel; job_n = sel; job_mode = mode; job_k = 0;
    endtask
    task automatic add_q(input int c, input int r);
        job_c[job_k] = c; job_r[job_k] = r; job_k++;
    endtask
    task automatic drop_inputs();
        iv4 = 0; iv8 = 0; iv12 = 0; ivn = 0;
    endtask
    task automatic drive_beat(input int i);
        col_b = 4'(job_c[i]); row_b = 4'(job_r[i]); num_b = 4'(job_k);
        ivn = (i == 0); mode_b = job_mode;
        iv4 = (job_sel == 4); iv8 = (job_sel == 8); iv12 = (job_sel == 12);
    endtask

    // Send a job, wait for its result beats and score them against the model.
    task automatic run_job(input string tag, input bit immediate);
        logic [31:0] e;
        ref_solve();
        for (int i = 0; i < job_k; i++) begin
            if (!(immediate && i == 0)) @(negedge clk);
            drive_beat(i);
        end
        timed_out = 1; lat = 0;
        for (int t = 0; t < LIMIT; t++) begin
            @(negedge clk);
            drop_inputs();
            lat++;
            if (dut_ov() == 1) begin timed_out = 0; break; end
        end
        check({tag, "_timeout"}, 32'(timed_out), 0);
        got_beats = 0;
        while (!timed_out && dut_ov() == 1 && got_beats < 17) begin
            got_out[got_beats]  = int'(dut_out());
            got_cnt[got_beats]  = int'(dut_cnt());
            got_fail[got_beats] = int'(dut_fail());
            got_beats++;
            @(negedge clk);
        end
        exp_q.delete();
        if (job_mode == MODE_FIRST && exp_found)
            for (int i = 0; i < job_n; i++) exp_q.push_back(32'(exp_board[i]));
        else
            exp_q.push_back(0);
        check({tag, "_beats"}, 32'(got_beats), 32'(exp_q.size()));
        for (int i = 0; i < got_beats && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            check({tag, "_out"}, 32'(got_out[i]), e);
            check({tag, "_fail"}, 32'(got_fail[i]), 32'(job_mode == MODE_FIRST && !exp_found));
            check({tag, "_cnt"}, 32'(got_cnt[i]),
                  (job_mode == MODE_COUNT) ? 32'((exp_count > 65535) ? 65535 : exp_count) : 0);
        end
        check({tag, "_idle_zero"}, dut_ov() | dut_out() | dut_cnt() | dut_fail(), 0);
    endtask

    int lit[4];
    int saved[16];
    int perm[16];
    bit seen;

    task automatic shuffle(input int n);
        int j, t;
        for (int i = 0; i < n; i++) perm[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    initial begin
        lit = '{1, 3, 0, 2};
        // Reset, with a load beat presented at the same time
        rst = 1; mode_b = 0; col_b = 0; row_b = 1; num_b = 1;
        iv4 = 1; iv8 = 0; iv12 = 0; ivn = 1;
        repeat (2) @(negedge clk);
        check("rst_ov", {29'd0, ov4, ov8, ov12}, 0);
        check("rst_out", {21'd0, o4, o8, o12}, 0);
        check("rst_cnt", {c4, c8 | c12}, 0);
        check("rst_fail", {29'd0, f4, f8, f12}, 0);
        check("rst_state4", {29'd0, st4}, {29'd0, S_IDLE});
        rst = 0;
        drop_inputs();
        @(negedge clk);
        check("post_rst_state4", {29'd0, st4}, {29'd0, S_IDLE});
        check("post_rst_ov4", {31'd0, ov4}, 0);

        // N=4 first solution with (0,1)
        set_job(4, MODE_FIRST); add_q(0, 1);
        run_job("t1", 0);
        for (int i = 0; i < 4; i++) check("t1_board", 32'(got_out[i]), 32'(lit[i]));

        // N=4 with (0,0): no solution
        set_job(4, MODE_FIRST); add_q(0, 0);
        run_job("t2", 0);

        // N=8 count with (0,0)
        set_job(8, MODE_COUNT); add_q(0, 0);
        run_job("t3", 0);
        check("t3_cnt4", 32'(got_cnt[0]), 4);

        // N=8 diagonal conflict in the pre-placed set
        set_job(8, MODE_FIRST); add_q(0, 0); add_q(1, 1);
        run_job("t4", 0);
        check("t4_latency", 32'(lat <= 3), 1);

        // N=12 first solution with (3,5), then a back-to-back count job
        set_job(12, MODE_FIRST); add_q(3, 5);
        run_job("t5", 0);
        check("t5_has_q", 32'(got_out[3]), 5);
        for (int i = 0; i < 12; i++) saved[i] = exp_board[i];
        shuffle(12);
        set_job(12, MODE_COUNT);
        for (int i = 0; i < 5; i++) add_q(perm[i], saved[perm[i]]);
        run_job("t5b", 1);

        // Reset in the middle of a long count search
        set_job(8, MODE_COUNT); add_q(0, 0);
        @(negedge clk); drive_beat(0);
        @(negedge clk); drop_inputs();
        repeat (20) @(negedge clk);
        check("t6_busy", 32'(st8 == S_SEARCH || st8 == S_BACK), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_rst_out", {ov8, o8, c8, f8}, 0);
        check("t6_rst_state", {29'd0, st8}, {29'd0, S_IDLE});
        seen = 0;
        repeat (40) begin @(negedge clk); if (ov8) seen = 1; end
        check("t6_quiet", 32'(seen), 0);
        set_job(4, MODE_FIRST); add_q(0, 1);
        run_job("t6_n4", 0);
        for (int i = 0; i < 4; i++) check("t6_board", 32'(got_out[i]), 32'(lit[i]));

        // Randomised N=8 jobs
        for (int j = 0; j < 6; j++) begin
            shuffle(8);
            set_job(8, 1'($urandom_range(0, 1)));
            for (int i = 0, k = $urandom_range(1, 3); i < k; i++)
                add_q(perm[i], $urandom_range(0, 7));
            run_job($sformatf("rnd%0d", j), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nqueen_solver.md
# nqueen_solver

Parametrised N-queens backtracking engine, successor to the fixed 12×12 solver. It accepts a set of pre-placed queens and runs in one of two modes: return the first completed board in column order, or count every completion. It sits in the same lab datapath slot as the earlier solver, with the same serial load/unload style, and adds explicit no-solution reporting.

## Interface
- `N`, 12, board size; legal 4..15.
- `W`, $clog2(N+1), width of row/column/count-of-queens fields.
- `CW`, 16, solution-counter width.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: one pre-placed queen per cycle.
- `col` input W: column of the queen, 0..N-1.
- `row` input W: row of the queen, 0..N-1.
- `in_valid_num` input 1: high only on the first `in_valid` cycle of a job.
- `in_num` input W: number of pre-placed queens K (1..N-1), sampled with `in_valid_num`.
- `in_mode` input 1: sampled with `in_valid_num`; 0 = first solution, 1 = count all.
- `out_valid` output 1: result beat.
- `out` output W: row of column i on the i-th beat (mode 0); 0 otherwise.
- `out_cnt` output CW: solution count (mode 1 beat); 0 otherwise.
- `out_fail` output 1: mode-0 no-solution beat.

## Operation
- States: IDLE, LOAD, SEARCH, BACK, OUT, DONE.
- IDLE/LOAD: each `in_valid` writes `pos[col]=row`, sets `fixed[col]`, `rowm[row]`, `d1[row+col]`, `d2[row-col+N-1]`.
  - If any of those bits is already set, set `conflict`.
  - After K beats, the block goes to SEARCH with c=0, r=0, cnt=0.
- SEARCH (one trial per cycle), checked in this order:
  - c==N: solution found. Mode 0 → OUT. Mode 1 → cnt++ (saturating at all-ones) → BACK.
  - `fixed[c]`: c++.
  - r==N: → BACK.
  - Row r safe (rowm, d1, d2 all clear): place the queen, `pos[c]=r`, c++, r=0.
  - Otherwise: r++.
- BACK:
  - Decrement c, skipping fixed columns.
  - If no non-fixed column remains below the old c: search exhausted → DONE.
  - Else clear the masks of `pos[c]`, set r=`pos[c]`+1 → SEARCH.
- `conflict` set at the end of LOAD: go straight to DONE (fail / count 0).
- OUT: N beats, `out=pos[0..N-1]`, then → IDLE.
- DONE:
  - One beat. Mode 0: `out_fail=1`, `out=0`. Mode 1: `out_cnt=cnt`, `out_fail=0`.
  - Then → IDLE.
- Returning to IDLE clears all masks, `fixed`, `pos`, `cnt` and `conflict`.
- Width rules:
  - Diagonal indices are computed W+1 bits wide.
  - r and c are compared against N at full width, so no wrap-around at N=15.

## Timing
- Reset: `out_valid`=0, `out`=0, `out_cnt`=0, `out_fail`=0, state IDLE, all masks cleared.
  - Reset asserted mid-LOAD, SEARCH or OUT aborts the job; the next cycle is IDLE.
- Input beats are consecutive; `in_valid` outside IDLE/LOAD is ignored.
- SEARCH is entered the cycle after the last `in_valid`.
- The first result beat comes ≥1 cycle after that; search latency is data-dependent.
- OUT: `out_valid` high for exactly N consecutive cycles. DONE: exactly 1 cycle.
- A new job may start (`in_valid`) on the cycle after the last `out_valid`.
- `out`, `out_cnt` and `out_fail` are 0 whenever `out_valid` is 0.
- Simultaneous events: `in_valid` together with `rst` → reset wins.

## Structure
- Shared package `nqueen_pkg` holds:
  - the state enum;
  - the mode encoding (MODE_FIRST=0, MODE_COUNT=1);
  - helper functions `d1_idx(r,c)` and `d2_idx(r,c,N)`.
- One sub-module, `nqueen_occupancy`: the row/d1/d2 mask bank.
  - Ports: set/clear of (r,c), a combinational `safe(r,c)` query, and a `hit` flag for load conflicts.

## Test plan
- N=4, mode 0, K=1, (col0,row1) → out = 1,3,0,2 over 4 beats, `out_fail`=0.
- N=4, mode 0, K=1, (col0,row0) → one beat, `out_fail`=1, `out`=0.
- N=8, mode 1, K=1, (col0,row0) → one beat, `out_cnt`=4.
- N=8, mode 0, K=2, (0,0),(1,1) → diagonal conflict → `out_fail`=1 within 3 cycles of the last input.
- N=12, mode 0, K=1, (col3,row5) → 12 beats, matching a software reference solver, valid board containing (3,5).
  - Follow it with a back-to-back N=12 mode-1 job to check that state is cleared between jobs.
- `rst` pulse mid-SEARCH → outputs 0 on the next cycle; a fresh N=4 job then yields 1,3,0,2.
